// File: rtl/operand_fetch_if.sv
// Bundle of the signals between the operand-fetch stage and the rest of the
// pipeline (fetch, register file, EX/MEM/WB feedback).
//
// Signals:
//   state      CPU run state; the stage updates only in the exec state
//   id_ir      instruction presented by instruction fetch
//   gr0..gr7   architectural registers from the writeback stage
//   ex_ir_in   instruction currently in EX (the stage's own ex_ir fed back)
//   ALUo       EX result of the current cycle
//   mem_ir     instruction in MEM
//   reg_C      MEM result, load data already merged
//   wb_ir      instruction in WB
//   reg_C1     WB result, written to the register file at the next edge
//   flush      taken branch/jump: discard the instruction in ID
//   ex_ir      registered instruction to EX
//   reg_A      registered operand A
//   reg_B      registered operand B
//   smdr       registered STORE data
//   stall      combinational; fetch holds pc and id_ir while high
//
// Modports: master = pipeline side driving the stage, slave = operand_fetch.
interface operand_fetch_if;
    logic        state;
    logic [15:0] id_ir;
    logic [15:0] gr0, gr1, gr2, gr3, gr4, gr5, gr6, gr7;
    logic [15:0] ex_ir_in;
    logic [15:0] ALUo;
    logic [15:0] mem_ir;
    logic [15:0] reg_C;
    logic [15:0] wb_ir;
    logic [15:0] reg_C1;
    logic        flush;
    logic [15:0] ex_ir;
    logic [15:0] reg_A;
    logic [15:0] reg_B;
    logic [15:0] smdr;
    logic        stall;

    modport master (
        output state, id_ir, gr0, gr1, gr2, gr3, gr4, gr5, gr6, gr7,
               ex_ir_in, ALUo, mem_ir, reg_C, wb_ir, reg_C1, flush,
        input  ex_ir, reg_A, reg_B, smdr, stall
    );

    modport slave (
        input  state, id_ir, gr0, gr1, gr2, gr3, gr4, gr5, gr6, gr7,
               ex_ir_in, ALUo, mem_ir, reg_C, wb_ir, reg_C1, flush,
        output ex_ir, reg_A, reg_B, smdr, stall
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage of the 5-stage pipeline.
// Selects source operands by instruction class, forwards in-flight results
// from EX, MEM and WB (in that priority), detects load-use hazards (stall +
// bubble) and registers instruction and operands into the ID/EX register.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high reset
//   bus    operand_fetch_if.slave (see the interface file for signal list)
module operand_fetch (
    input  logic              clock,
    input  logic              reset,
    operand_fetch_if.slave    bus
);
    // Opcode encodings (ir[15:11]) and run state.
    localparam logic [0:0] EXEC  = 1'b1;
    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] SHL   = 5'b00100;
    localparam logic [4:0] SHR   = 5'b00101;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] CMP   = 5'b01100;
    localparam logic [4:0] AND   = 5'b01101;
    localparam logic [4:0] OR    = 5'b01110;
    localparam logic [4:0] XOR   = 5'b01111;
    localparam logic [4:0] ADDC  = 5'b10001;
    localparam logic [4:0] SUBC  = 5'b10010;
    localparam logic [4:0] CAL   = 5'b10011;
    localparam logic [4:0] CAR   = 5'b10100;
    localparam logic [4:0] MOVI  = 5'b10101;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;
    localparam logic [4:0] BN    = 5'b11100;
    localparam logic [4:0] BNN   = 5'b11101;
    localparam logic [4:0] BC    = 5'b11110;
    localparam logic [4:0] BNC   = 5'b11111;

    logic [15:0] ex_ir_q, ex_ir_d;
    logic [15:0] reg_a_q, reg_a_d;
    logic [15:0] reg_b_q, reg_b_d;
    logic [15:0] smdr_q,  smdr_d;

    logic [15:0] gr [8];
    logic [15:0] id_ir, ex_ir_in, mem_ir, wb_ir;
    logic [15:0] alu_o, reg_c, reg_c1;

    assign gr[0] = bus.gr0;
    assign gr[1] = bus.gr1;
    assign gr[2] = bus.gr2;
    assign gr[3] = bus.gr3;
    assign gr[4] = bus.gr4;
    assign gr[5] = bus.gr5;
    assign gr[6] = bus.gr6;
    assign gr[7] = bus.gr7;
    assign id_ir    = bus.id_ir;
    assign ex_ir_in = bus.ex_ir_in;
    assign mem_ir   = bus.mem_ir;
    assign wb_ir    = bus.wb_ir;
    assign alu_o    = bus.ALUo;
    assign reg_c    = bus.reg_C;
    assign reg_c1   = bus.reg_C1;

    function automatic logic is_writer(input logic [4:0] op);
        case (op)
            LOAD, MOVI, ADD, ADDI, ADDC, SUB, SUBI, SUBC,
            AND, OR, XOR, SHL, SHR, CAL, CAR: is_writer = 1'b1;
            default:                          is_writer = 1'b0;
        endcase
    endfunction

    // Youngest in-flight writer wins. WB is included so a register written
    // on the same edge ID samples it never reads the stale gr value.
    function automatic logic [15:0] fwd(input logic [2:0] n);
        if (is_writer(ex_ir_in[15:11]) && ex_ir_in[10:8] == n)
            fwd = alu_o;
        else if (is_writer(mem_ir[15:11]) && mem_ir[10:8] == n)
            fwd = reg_c;
        else if (is_writer(wb_ir[15:11]) && wb_ir[10:8] == n)
            fwd = reg_c1;
        else
            fwd = gr[n];
    endfunction

    logic [15:0] rs_v, rt_v, rd_v;
    logic [15:0] sel_a, sel_b, sel_smdr;
    logic        use_rs, use_rt, use_rd;
    logic        hazard, stall;

    always_comb begin
        rs_v     = fwd(id_ir[6:4]);
        rt_v     = fwd(id_ir[2:0]);
        rd_v     = fwd(id_ir[10:8]);
        sel_a    = 16'h0000;
        sel_b    = 16'h0000;
        sel_smdr = 16'h0000;
        use_rs   = 1'b0;
        use_rt   = 1'b0;
        use_rd   = 1'b0;
        case (id_ir[15:11])
            ADD, ADDC, SUB, SUBC, AND, OR, XOR, CMP: begin
                use_rs = 1'b1;
                use_rt = 1'b1;
                sel_a  = rs_v;
                sel_b  = rt_v;
            end
            ADDI, SUBI, BZ, BNZ, BN, BNN, BC, BNC: begin
                use_rd = 1'b1;
                sel_a  = rd_v;
                sel_b  = {8'h00, id_ir[7:0]};
            end
            MOVI, JUMP: begin
                sel_b = {8'h00, id_ir[7:0]};
            end
            SHL, SHR, LOAD: begin
                use_rs = 1'b1;
                sel_a  = rs_v;
                sel_b  = {12'h000, id_ir[3:0]};
            end
            STORE: begin
                use_rs   = 1'b1;
                use_rd   = 1'b1;
                sel_a    = rs_v;
                sel_b    = {12'h000, id_ir[3:0]};
                sel_smdr = rd_v;
            end
            default: ;
        endcase

        // Only fields the class really reads can create a load-use hazard.
        hazard = (ex_ir_in[15:11] == LOAD) &&
                 ((use_rs && ex_ir_in[10:8] == id_ir[6:4]) ||
                  (use_rt && ex_ir_in[10:8] == id_ir[2:0]) ||
                  (use_rd && ex_ir_in[10:8] == id_ir[10:8]));
        stall  = hazard && !bus.flush && !reset;
    end

    always_comb begin
        ex_ir_d = ex_ir_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        smdr_d  = smdr_q;
        if (bus.state == EXEC) begin
            if (bus.flush || stall) begin
                // Bubble into EX; on a stall IF holds id_ir so it is re-decoded.
                ex_ir_d = {NOP, 11'h000};
                reg_a_d = 16'h0000;
                reg_b_d = 16'h0000;
                smdr_d  = 16'h0000;
            end else begin
                ex_ir_d = id_ir;
                reg_a_d = sel_a;
                reg_b_d = sel_b;
                smdr_d  = sel_smdr;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_ir_q <= 16'h0000;
            reg_a_q <= 16'h0000;
            reg_b_q <= 16'h0000;
            smdr_q  <= 16'h0000;
        end else begin
            ex_ir_q <= ex_ir_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            smdr_q  <= smdr_d;
        end
    end

    assign bus.ex_ir = ex_ir_q;
    assign bus.reg_A = reg_a_q;
    assign bus.reg_B = reg_b_q;
    assign bus.smdr  = smdr_q;
    assign bus.stall = stall;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, plain reads, forwarding priority,
// load-use stall, STORE/immediate selection, flush and halt behaviour.
module tb_operand_fetch;
    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] MOVI  = 5'b10101;

    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction builders
    function automatic logic [15:0] r3(input logic [4:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [2:0] b);
        r3 = {op, d, 1'b0, a, 1'b0, b};
    endfunction

    function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] d,
                                       input logic [7:0] imm);
        ri = {op, d, imm};
    endfunction

    function automatic logic [15:0] rs(input logic [4:0] op, input logic [2:0] d,
                                       input logic [2:0] a, input logic [3:0] imm);
        rs = {op, d, 1'b0, a, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge and settle outputs away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_flight();
        bus.ex_ir_in = 16'h0000;
        bus.mem_ir   = 16'h0000;
        bus.wb_ir    = 16'h0000;
        bus.ALUo     = 16'h0000;
        bus.reg_C    = 16'h0000;
        bus.reg_C1   = 16'h0000;
        bus.flush    = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        bus.state = 1'b1;
        bus.gr0 = 16'h0000; bus.gr1 = 16'h0010; bus.gr2 = 16'h1234; bus.gr3 = 16'h0011;
        bus.gr4 = 16'h4444; bus.gr5 = 16'h0505; bus.gr6 = 16'h00FF; bus.gr7 = 16'h7070;
        clear_flight();

        // Reset with a would-be hazard present: stall must stay low.
        reset      = 1'b1;
        bus.id_ir  = r3(ADD, 3'd1, 3'd2, 3'd3);
        bus.ex_ir_in = rs(LOAD, 3'd2, 3'd0, 4'd0);
        tick();
        tick();
        check("rst_ex_ir", bus.ex_ir, 16'h0000);
        check("rst_reg_A", bus.reg_A, 16'h0000);
        check("rst_reg_B", bus.reg_B, 16'h0000);
        check("rst_smdr",  bus.smdr,  16'h0000);
        check("rst_stall", {15'h0, bus.stall}, 16'h0000);

        // Plain read
        reset = 1'b0;
        clear_flight();
        tick();
        check("plain_A",  bus.reg_A, 16'h1234);
        check("plain_B",  bus.reg_B, 16'h0011);
        check("plain_ir", bus.ex_ir, r3(ADD, 3'd1, 3'd2, 3'd3));
        check("plain_smdr", bus.smdr, 16'h0000);

        // Forwarding priority on gr2
        bus.ex_ir_in = r3(ADD, 3'd2, 3'd0, 3'd0);
        bus.mem_ir   = ri(ADDI, 3'd2, 8'h01);
        bus.wb_ir    = ri(MOVI, 3'd2, 8'h02);
        bus.ALUo = 16'hAAAA; bus.reg_C = 16'hBBBB; bus.reg_C1 = 16'hCCCC;
        tick();
        check("fwd_ex",   bus.reg_A, 16'hAAAA);
        check("fwd_ex_B", bus.reg_B, 16'h0011);
        bus.ex_ir_in = 16'h0000;
        tick();
        check("fwd_mem", bus.reg_A, 16'hBBBB);
        bus.mem_ir = 16'h0000;
        tick();
        check("fwd_wb", bus.reg_A, 16'hCCCC);
        // STORE is not a writer even though its [10:8] names gr2
        bus.ex_ir_in = rs(STORE, 3'd2, 3'd0, 4'd0);
        tick();
        check("fwd_nonwriter", bus.reg_A, 16'hCCCC);
        // Same-edge WB write of gr3 replaces stale register-file value
        bus.ex_ir_in = 16'h0000;
        bus.wb_ir  = ri(MOVI, 3'd3, 8'h77);
        bus.reg_C1 = 16'h7777;
        tick();
        check("wb_same_edge_B", bus.reg_B, 16'h7777);
        check("wb_plain_A",     bus.reg_A, 16'h1234);

        // Unused field (ADDI imm bits look like gr2) must not stall or forward
        clear_flight();
        bus.id_ir    = ri(ADDI, 3'd5, 8'h23);
        bus.ex_ir_in = rs(LOAD, 3'd2, 3'd0, 4'd0);
        bus.ALUo     = 16'hDEAD;
        settle();
        check("unused_no_stall", {15'h0, bus.stall}, 16'h0000);
        tick();
        check("addi_A", bus.reg_A, 16'h0505);
        check("addi_B", bus.reg_B, 16'h0023);

        // Load-use hazard on rs
        clear_flight();
        bus.ex_ir_in = rs(LOAD, 3'd4, 3'd0, 4'd2);
        bus.id_ir    = r3(SUB, 3'd1, 3'd4, 3'd5);
        settle();
        check("lu_stall", {15'h0, bus.stall}, 16'h0001);
        tick();
        check("lu_bubble_ir", bus.ex_ir, 16'h0000);
        check("lu_bubble_A",  bus.reg_A, 16'h0000);
        check("lu_bubble_B",  bus.reg_B, 16'h0000);
        bus.ex_ir_in = 16'h0000;
        bus.mem_ir   = rs(LOAD, 3'd4, 3'd0, 4'd2);
        bus.reg_C    = 16'h0055;
        settle();
        check("lu_clear", {15'h0, bus.stall}, 16'h0000);
        tick();
        check("lu_fwd_A", bus.reg_A, 16'h0055);
        check("lu_B",     bus.reg_B, 16'h0505);
        check("lu_ir",    bus.ex_ir, r3(SUB, 3'd1, 3'd4, 3'd5));

        // Load-use hazard on rt field
        clear_flight();
        bus.ex_ir_in = rs(LOAD, 3'd4, 3'd0, 4'd2);
        bus.id_ir    = r3(SUB, 3'd1, 3'd5, 3'd4);
        settle();
        check("lu_rt_stall", {15'h0, bus.stall}, 16'h0001);

        // STORE data and immediate, then hazard on the data register
        clear_flight();
        bus.id_ir = rs(STORE, 3'd6, 3'd1, 4'h3);
        tick();
        check("st_smdr", bus.smdr,  16'h00FF);
        check("st_A",    bus.reg_A, 16'h0010);
        check("st_B",    bus.reg_B, 16'h0003);
        bus.ex_ir_in = rs(LOAD, 3'd6, 3'd0, 4'd0);
        settle();
        check("st_data_stall", {15'h0, bus.stall}, 16'h0001);

        // MOVI: A = 0, B = imm8
        clear_flight();
        bus.id_ir = ri(MOVI, 3'd1, 8'h5A);
        tick();
        check("movi_A", bus.reg_A, 16'h0000);
        check("movi_B", bus.reg_B, 16'h005A);

        // Flush during a hazard
        bus.ex_ir_in = rs(LOAD, 3'd4, 3'd0, 4'd2);
        bus.id_ir    = r3(SUB, 3'd1, 3'd4, 3'd5);
        bus.flush    = 1'b1;
        settle();
        check("flush_stall", {15'h0, bus.stall}, 16'h0000);
        tick();
        check("flush_ir", bus.ex_ir, 16'h0000);
        check("flush_B",  bus.reg_B, 16'h0000);

        // Load a known value, then halt for 3 cycles
        clear_flight();
        bus.id_ir = r3(ADD, 3'd1, 3'd2, 3'd3);
        tick();
        check("pre_halt_A", bus.reg_A, 16'h1234);
        bus.state    = 1'b0;
        bus.id_ir    = rs(STORE, 3'd6, 3'd1, 4'h3);
        bus.ex_ir_in = rs(LOAD, 3'd1, 3'd0, 4'd0);
        settle();
        check("halt_stall_eval", {15'h0, bus.stall}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_ir",   bus.ex_ir, r3(ADD, 3'd1, 3'd2, 3'd3));
            check("halt_A",    bus.reg_A, 16'h1234);
            check("halt_B",    bus.reg_B, 16'h0011);
            check("halt_smdr", bus.smdr,  16'h0000);
        end
        bus.state = 1'b1;

        // Reset during a stall, then hazard clears once ex_ir is NOP
        bus.id_ir    = r3(SUB, 3'd1, 3'd4, 3'd5);
        bus.ex_ir_in = rs(LOAD, 3'd4, 3'd0, 4'd2);
        settle();
        check("pre_rst_stall", {15'h0, bus.stall}, 16'h0001);
        reset = 1'b1;
        settle();
        check("rst_forces_stall0", {15'h0, bus.stall}, 16'h0000);
        tick();
        check("rst2_ir", bus.ex_ir, 16'h0000);
        check("rst2_A",  bus.reg_A, 16'h0000);
        reset = 1'b0;
        bus.ex_ir_in = {NOP, 11'h000};
        settle();
        check("post_rst_stall", {15'h0, bus.stall}, 16'h0000);
        tick();
        check("post_rst_ir", bus.ex_ir, r3(SUB, 3'd1, 3'd4, 3'd5));
        check("post_rst_A",  bus.reg_A, 16'h4444);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage of the 5-stage pipeline, between instruction fetch and execute. Reads the eight general registers driven by the writeback stage, selects source operands per instruction class, forwards results still in flight from EX, MEM and WB, and detects load-use hazards by stalling fetch and injecting a bubble. Registers the instruction and its operands into the ID/EX pipeline register.

## Interface
No parameters. Opcode and register-field encodings come from `define.v`: `exec`, `NOP`, `LOAD`, `STORE`, `MOVI`, and the ALU, shift, branch and jump mnemonics.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- state  in  1  CPU run state; registers update only when state == `exec`
- id_ir  in  16  instruction from IF
- gr0..gr7  in  16 each  architectural registers from the writeback stage
- ex_ir_in  in  16  instruction currently in EX (this block's ex_ir, fed back)
- ALUo  in  16  EX result, same cycle
- mem_ir  in  16  instruction in MEM
- reg_C  in  16  MEM result; load data already merged
- wb_ir  in  16  instruction in WB
- reg_C1  in  16  WB result, written to the register file at the next edge
- flush  in  1  taken branch or jump; discard the instruction in ID
- ex_ir  out  16  registered instruction to EX
- reg_A  out  16  registered operand A
- reg_B  out  16  registered operand B
- smdr  out  16  registered STORE data
- stall  out  1  combinational; IF holds pc and id_ir while high

## Operation
- Writers: LOAD, MOVI, ADD, ADDI, ADDC, SUB, SUBI, SUBC, AND, OR, XOR, SHL, SHR, CAL, CAR. Destination field is ir[10:8]. No other opcode is a forwarding source.
- Operand selection by id_ir[15:11]:
  - Three-register ALU ops (ADD, ADDC, SUB, SUBC, AND, OR, XOR, CMP): A = R[ir[6:4]], B = R[ir[2:0]].
  - ADDI, SUBI, branches: A = R[ir[10:8]], B = {8'h00, ir[7:0]}.
  - MOVI, JUMP: A = 0, B = {8'h00, ir[7:0]}.
  - SHL, SHR, LOAD: A = R[ir[6:4]], B = {12'h000, ir[3:0]}.
  - STORE: same A and B as LOAD; smdr = R[ir[10:8]].
  - All other opcodes: A = B = smdr = 0.
- R[n] is forwarded. Highest-priority match wins: writer ex_ir_in with dest n gives ALUo; writer mem_ir with dest n gives reg_C; writer wb_ir with dest n gives reg_C1; otherwise gr_n.
- Forwarding applies only to register fields actually used by the current class. Unused fields never cause a forward or a stall.
- Load-use stall: stall = 1 when ex_ir_in is LOAD and its dest equals any used source field of id_ir. flush forces stall to 0.
- Update priority at each rising edge:
  1. reset: ex_ir, reg_A, reg_B, smdr ← 0.
  2. state != `exec`: hold all registers.
  3. flush: ex_ir ← `NOP`; operands ← 0.
  4. stall: ex_ir ← `NOP`; operands ← 0. IF keeps id_ir, so the instruction is re-evaluated next cycle against the load, which has moved to MEM.
  5. Otherwise: ex_ir ← id_ir; reg_A, reg_B, smdr ← selected and forwarded values.
- All arithmetic is 16-bit. No operation here widens or sign-extends; immediates are zero-extended as listed.

## Timing
- Reset values: ex_ir = 16'h0000 (`NOP`), reg_A = reg_B = smdr = 0.
- stall is 0 while reset is high. While state != `exec`, stall is still evaluated combinationally.
- Latency: one cycle from id_ir to ex_ir and operands.
- One stall cycle per load-use hazard. A dependent instruction two slots behind a LOAD gets reg_C with no stall.
- Same-edge write: when WB writes register n on the edge where ID samples R[n], ID takes reg_C1, never the stale gr_n.
- If reset asserts during a stall, the next edge gives the reset values. With id_ir unchanged, the hazard is re-evaluated after reset deasserts, and it clears because ex_ir is now NOP.

## Test plan
- Reset: assert reset for 2 cycles with id_ir = ADD → ex_ir = 0, reg_A = reg_B = smdr = 0, stall = 0.
- Plain read: gr2 = 16'h1234, gr3 = 16'h0011, id_ir = ADD gr1,gr2,gr3 with no writers in flight → next cycle reg_A = 16'h1234, reg_B = 16'h0011, ex_ir = id_ir.
- Forward priority: ex_ir_in, mem_ir and wb_ir all write gr2, with ALUo = 16'hAAAA, reg_C = 16'hBBBB, reg_C1 = 16'hCCCC → reg_A = 16'hAAAA. Remove EX writer → 16'hBBBB. Remove MEM writer → 16'hCCCC.
- Load-use: ex_ir_in = LOAD gr4,gr0,2 and id_ir = SUB gr1,gr4,gr5 → stall = 1 and ex_ir becomes NOP. Next cycle, with the LOAD in MEM and reg_C = 16'h0055 → reg_A = 16'h0055, stall = 0.
- STORE data and immediate: id_ir = STORE gr6,gr1,4'h3 with gr6 = 16'h00FF, gr1 = 16'h0010 → smdr = 16'h00FF, reg_A = 16'h0010, reg_B = 16'h0003.
- flush with a simultaneous hazard, then halt: flush = 1 during a load-use hazard → stall = 0 and ex_ir = NOP. Then state != `exec` for 3 cycles → all outputs hold.
